// File: rtl/mem_port_arbiter.sv
// Four-requester round-robin arbiter sharing one memory port; grant held for a whole transaction.
// Latency: request seen in IDLE at cycle N -> memory strobe at N+1; req_resp is combinational with mem_resp.
// Backpressure: no preemption; other requesters wait while BUSY; one idle cycle between transactions.
//
// Ports:
//   i_clk, i_reset_n                  clock, asynchronous active-low reset
//   i_req_read/i_req_write [3:0]      per-port read/write request
//   i_req_address/i_req_wdata         per-port address/write data, packed, port i in [i]
//   o_req_rdata                       broadcast copy of i_mem_rdata
//   o_req_resp [3:0]                  per-port completion pulse
//   o_mem_read/o_mem_write            shared-port strobes
//   o_mem_address/o_mem_wdata         shared-port address/write data
//   i_mem_rdata, i_mem_resp           shared-port read data and completion
//   o_grant [3:0]                     one-hot owner, 0 when idle
//   o_sel [1:0]                       index of current/last owner
module mem_port_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [3:0]            i_req_read,
  input  logic [3:0]            i_req_write,
  input  logic [3:0][WIDTH-1:0] i_req_address,
  input  logic [3:0][WIDTH-1:0] i_req_wdata,
  output logic [WIDTH-1:0]      o_req_rdata,
  output logic [3:0]            o_req_resp,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [WIDTH-1:0]      o_mem_address,
  output logic [WIDTH-1:0]      o_mem_wdata,
  input  logic [WIDTH-1:0]      i_mem_rdata,
  input  logic                  i_mem_resp,
  output logic [3:0]            o_grant,
  output logic [1:0]            o_sel
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     r_state;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;

  state_t     w_next_state;
  logic [1:0] w_next_sel;
  logic [1:0] w_next_ptr;
  logic [3:0] w_req;
  logic       w_any;
  logic [1:0] w_winner;

  assign w_req       = i_req_read | i_req_write;
  assign w_any       = |w_req;
  assign o_req_rdata = i_mem_rdata;
  assign o_sel       = r_sel;

  // Scan from the highest offset down so the requester closest to r_ptr
  // is the last (and therefore final) assignment.
  always_comb begin
    w_winner = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (w_req[r_ptr + 2'(k)]) begin
        w_winner = r_ptr + 2'(k);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_sel   <= w_next_sel;
      r_ptr   <= w_next_ptr;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_sel    = r_sel;
    w_next_ptr    = r_ptr;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_mem_address = '0;
    o_mem_wdata   = '0;
    o_grant       = 4'b0000;
    o_req_resp    = 4'b0000;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next_state = BUSY;
          w_next_sel   = w_winner;
          w_next_ptr   = w_winner + 2'd1;
        end
      end
      BUSY: begin
        o_grant       = 4'b0001 << r_sel;
        o_mem_read    = i_req_read[r_sel];
        o_mem_write   = i_req_write[r_sel];
        o_mem_address = i_req_address[r_sel];
        o_mem_wdata   = i_req_wdata[r_sel];
        if (i_mem_resp) begin
          o_req_resp[r_sel] = 1'b1;
          w_next_state      = IDLE;
        end else if (!w_req[r_sel]) begin
          // Owner withdrew before completion: release without a response.
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic             clk;
  logic             reset_n;
  logic [3:0]       req_read;
  logic [3:0]       req_write;
  logic [3:0][15:0] req_address;
  logic [3:0][15:0] req_wdata;
  logic [15:0]      req_rdata;
  logic [3:0]       req_resp;
  logic             mem_read;
  logic             mem_write;
  logic [15:0]      mem_address;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_resp;
  logic [3:0]       grant;
  logic [1:0]       sel;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.WIDTH(16)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_req_read   (req_read),
    .i_req_write  (req_write),
    .i_req_address(req_address),
    .i_req_wdata  (req_wdata),
    .o_req_rdata  (req_rdata),
    .o_req_resp   (req_resp),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_mem_address(mem_address),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_mem_resp   (mem_resp),
    .o_grant      (grant),
    .o_sel        (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_read    = '0;
    req_write   = '0;
    req_address = '0;
    req_wdata   = '0;
    mem_rdata   = '0;
    mem_resp    = 1'b0;
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled after this.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    req_read  = 4'b1111;
    mem_rdata = 16'h5A5A;
    mem_resp  = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (req_resp !== 4'b0000) begin failures++; $display("FAIL reset_resp got=%b exp=0000", req_resp); end
    checks++; if ({mem_address, mem_wdata} !== 32'h0) begin failures++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_address, mem_wdata}); end
    checks++; if (req_rdata !== 16'h5A5A) begin failures++; $display("FAIL reset_rdata got=%h exp=5a5a", req_rdata); end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    req_read[2]    = 1'b1;
    req_address[2] = 16'h1234;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rd_idle_grant got=%b exp=0000", grant); end
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL rd_grant got=%b exp=0100", grant); end
    checks++; if (sel !== 2'd2) begin failures++; $display("FAIL rd_sel got=%0d exp=2", sel); end
    checks++; if (mem_read !== 1'b1 || mem_address !== 16'h1234) begin failures++; $display("FAIL rd_mem got=%b/%h exp=1/1234", mem_read, mem_address); end
    tick();
    tick();
    checks++; if (req_resp !== 4'b0000 || grant !== 4'b0100) begin failures++; $display("FAIL rd_hold got=%b/%b exp=0000/0100", req_resp, grant); end
    mem_resp = 1'b1;
    #1;
    checks++; if (req_resp !== 4'b0100) begin failures++; $display("FAIL rd_resp got=%b exp=0100", req_resp); end
    tick();
    req_read = '0;
    mem_resp = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || mem_read !== 1'b0) begin failures++; $display("FAIL rd_release got=%b/%b exp=0000/0", grant, mem_read); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    req_read = 4'b1111;
    for (int i = 0; i < 4; i++) req_address[i] = 16'hA000 + 16'(i);
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << (n % 4);
      tick();
      mem_resp = 1'b1;
      #1;
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, grant, exp_g); end
      checks++; if (req_resp !== exp_g) begin failures++; $display("FAIL rr_resp n=%0d got=%b exp=%b", n, req_resp, exp_g); end
      checks++; if (mem_address !== 16'hA000 + 16'(n % 4)) begin failures++; $display("FAIL rr_addr n=%0d got=%h exp=%h", n, mem_address, 16'hA000 + 16'(n % 4)); end
      tick();
      mem_resp = 1'b0;
      #1;
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rr_idle n=%0d got=%b exp=0000", n, grant); end
    end
    clear_inputs();
  endtask

  task automatic test_no_preempt();
    do_reset();
    req_write[0]   = 1'b1;
    req_address[0] = 16'h0C00;
    req_wdata[0]   = 16'hD00D;
    tick();
    checks++; if (grant !== 4'b0001 || mem_write !== 1'b1 || mem_wdata !== 16'hD00D) begin failures++; $display("FAIL np_wr got=%b/%b/%h exp=0001/1/d00d", grant, mem_write, mem_wdata); end
    req_read[1]    = 1'b1;
    req_address[1] = 16'h0111;
    #1;
    checks++; if (grant !== 4'b0001 || sel !== 2'd0 || mem_read !== 1'b0) begin failures++; $display("FAIL np_hold got=%b/%0d/%b exp=0001/0/0", grant, sel, mem_read); end
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL np_hold2 got=%b exp=0001", grant); end
    mem_resp = 1'b1;
    #1;
    checks++; if (req_resp !== 4'b0001) begin failures++; $display("FAIL np_resp0 got=%b exp=0001", req_resp); end
    tick();
    req_write = '0;
    mem_resp  = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL np_idle got=%b exp=0000", grant); end
    tick();
    checks++; if (grant !== 4'b0010 || mem_read !== 1'b1 || mem_address !== 16'h0111) begin failures++; $display("FAIL np_p1 got=%b/%b/%h exp=0010/1/0111", grant, mem_read, mem_address); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    req_read = 4'b1111;
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL np_ptr got=%b exp=0100", grant); end
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    req_read[3]    = 1'b1;
    req_address[3] = 16'h3333;
    tick();
    checks++; if (grant !== 4'b1000 || sel !== 2'd3 || mem_read !== 1'b1) begin failures++; $display("FAIL ab_grant got=%b/%0d/%b exp=1000/3/1", grant, sel, mem_read); end
    req_read = '0;
    #1;
    checks++; if (mem_read !== 1'b0 || req_resp !== 4'b0000) begin failures++; $display("FAIL ab_drop got=%b/%b exp=0/0000", mem_read, req_resp); end
    tick();
    checks++; if (grant !== 4'b0000 || req_resp !== 4'b0000) begin failures++; $display("FAIL ab_idle got=%b/%b exp=0000/0000", grant, req_resp); end
    req_read = 4'b1111;
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL ab_ptr got=%b exp=0001", grant); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req_write[1]   = 1'b1;
    req_address[1] = 16'h4444;
    tick();
    checks++; if (mem_write !== 1'b1 || grant !== 4'b0010) begin failures++; $display("FAIL rb_busy got=%b/%b exp=1/0010", mem_write, grant); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || grant !== 4'b0000 || sel !== 2'd0) begin failures++; $display("FAIL rb_async got=%b/%b/%0d exp=0/0000/0", mem_write, grant, sel); end
    req_write = '0;
    #1;
    reset_n  = 1'b1;
    mem_resp = 1'b1;
    #1;
    checks++; if (req_resp !== 4'b0000) begin failures++; $display("FAIL rb_late_resp got=%b exp=0000", req_resp); end
    tick();
    checks++; if (req_resp !== 4'b0000 || grant !== 4'b0000) begin failures++; $display("FAIL rb_after got=%b/%b exp=0000/0000", req_resp, grant); end
    clear_inputs();
  endtask

  task automatic test_rdata();
    do_reset();
    req_read[1] = 1'b1;
    tick();
    mem_rdata = 16'hBEEF;
    mem_resp  = 1'b1;
    #1;
    checks++; if (req_rdata !== 16'hBEEF) begin failures++; $display("FAIL rdata_val got=%h exp=beef", req_rdata); end
    checks++; if (req_resp !== 4'b0010) begin failures++; $display("FAIL rdata_resp got=%b exp=0010", req_resp); end
    tick();
    clear_inputs();
  endtask

  // Reference model: owner index or idle, plus the rotating priority pointer.
  task automatic test_random();
    bit         m_busy;
    int         m_sel;
    int         m_ptr;
    int         p;
    bit         found;
    logic [3:0] rq;
    logic [3:0] e_grant;
    logic [3:0] e_resp;
    logic       e_rd;
    logic       e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
    do_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_read  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      req_write = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      if (m_busy && $urandom_range(0, 3) != 0) req_read[m_sel] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        req_address[i] = 16'($urandom);
        req_wdata[i]   = 16'($urandom);
      end
      mem_rdata = 16'($urandom);
      mem_resp  = ($urandom_range(0, 2) == 0);
      #1;
      rq      = req_read | req_write;
      e_grant = m_busy ? 4'(1 << m_sel) : 4'b0000;
      e_resp  = (m_busy && mem_resp) ? 4'(1 << m_sel) : 4'b0000;
      e_rd    = m_busy ? req_read[m_sel] : 1'b0;
      e_wr    = m_busy ? req_write[m_sel] : 1'b0;
      e_addr  = m_busy ? req_address[m_sel] : 16'h0;
      e_wd    = m_busy ? req_wdata[m_sel] : 16'h0;
      checks++; if (grant !== e_grant || sel !== 2'(m_sel)) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b/%0d exp=%b/%0d", cyc, grant, sel, e_grant, m_sel); end
      checks++; if (req_resp !== e_resp) begin failures++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", cyc, req_resp, e_resp); end
      checks++; if ({mem_read, mem_write, mem_address, mem_wdata} !== {e_rd, e_wr, e_addr, e_wd}) begin failures++; $display("FAIL rnd_mem cyc=%0d got=%b%b/%h/%h exp=%b%b/%h/%h", cyc, mem_read, mem_write, mem_address, mem_wdata, e_rd, e_wr, e_addr, e_wd); end
      checks++; if (req_rdata !== mem_rdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, req_rdata, mem_rdata); end
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          p = (m_ptr + k) % 4;
          if (!found && rq[p]) begin
            found  = 1'b1;
            m_sel  = p;
            m_ptr  = (p + 1) % 4;
            m_busy = 1'b1;
          end
        end
      end else if (mem_resp || !rq[m_sel]) begin
        m_busy = 1'b0;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_no_preempt();
    test_abort();
    test_reset_mid_busy();
    test_rdata();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
